// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit: request,
// operands, stall/busy/done status and HI/LO results.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;

    modport master (
        output start, op, src_a, src_b,
        input  stall, busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, op, src_a, src_b,
        output stall, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine producing HI/LO for the MIPS EX stage.
// Define MULDIV_FASTMUL_EN to compute multiplies combinationally in the accept cycle.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             CLR,
    ex_muldiv_unit_if.slave mdu
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] ITERS = 6'd32;

    state_t            state;
    state_t            state_nx;
    logic              stall;
    logic [1:0]        op_q;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [5:0]        cnt;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;

    logic              is_div;
    logic              is_signed;
    logic              div_zero;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nx;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   quo_nx;
    logic [2*XLEN-1:0] prod_fix;

    function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                   input logic use_sign);
        logic [XLEN-1:0] r;
        r = (use_sign && v[XLEN-1]) ? $unsigned(-v) : $unsigned(v);
        return r;
    endfunction

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign is_div    = mdu.op[1];
    assign is_signed = ~mdu.op[0];
    assign div_zero  = is_div && (mdu.src_b == '0);

    // One shift-add multiply step and one restoring divide step per cycle.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_nx    = {mul_sum, acc[XLEN-1:1]};
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        if (!div_diff[XLEN]) begin
            rem_nx = div_diff[XLEN-1:0];
            quo_nx = {acc[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = div_shift[XLEN-1:0];
            quo_nx = {acc[XLEN-2:0], 1'b0};
        end
        prod_fix = neg_dword(mul_nx, neg_q);
    end

`ifdef MULDIV_FASTMUL_EN
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] fast_prod;

    // Low 64 bits of a 64x64 product of extended operands equal the signed or unsigned result.
    always_comb begin
        ext_a     = {{XLEN{is_signed & mdu.src_a[XLEN-1]}}, mdu.src_a};
        ext_b     = {{XLEN{is_signed & mdu.src_b[XLEN-1]}}, mdu.src_b};
        fast_prod = ext_a * ext_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (CLR) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mdu.start) begin
                    stall = 1'b1;
`ifdef MULDIV_FASTMUL_EN
                    state_nx = (div_zero || !is_div) ? DONE : RUN;
`else
                    state_nx = div_zero ? DONE : RUN;
`endif
                end
            end
            RUN: begin
                stall = 1'b1;
                if (cnt == 6'd1) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mdu.start) begin
                        op_q   <= mdu.op;
                        neg_q  <= is_signed & (mdu.src_a[XLEN-1] ^ mdu.src_b[XLEN-1]);
                        neg_r  <= is_signed & mdu.src_a[XLEN-1];
                        mag_a  <= magnitude(mdu.src_a, is_signed);
                        mag_b  <= magnitude(mdu.src_b, is_signed);
                        acc    <= {{XLEN{1'b0}}, is_div ? magnitude(mdu.src_a, is_signed)
                                                       : magnitude(mdu.src_b, is_signed)};
                        rem    <= '0;
                        cnt    <= ITERS;
                        busy_q <= (state_nx == RUN);
                        if (div_zero) begin
                            done_q <= 1'b1;
                            hi_q   <= mdu.src_a;
                            lo_q   <= '1;
                        end
`ifdef MULDIV_FASTMUL_EN
                        else if (!is_div) begin
                            done_q <= 1'b1;
                            hi_q   <= fast_prod[2*XLEN-1:XLEN];
                            lo_q   <= fast_prod[XLEN-1:0];
                        end
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt - 6'd1;
                    acc <= op_q[1] ? {{XLEN{1'b0}}, quo_nx} : mul_nx;
                    rem <= rem_nx;
                    if (cnt == 6'd1) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        if (op_q[1]) begin
                            hi_q <= neg_word(rem_nx, neg_r);
                            lo_q <= neg_word(quo_nx, neg_q);
                        end else begin
                            hi_q <= prod_fix[2*XLEN-1:XLEN];
                            lo_q <= prod_fix[XLEN-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mdu.stall  = stall;
    assign mdu.busy   = busy_q;
    assign mdu.done   = done_q;
    assign mdu.hi_out = hi_q;
    assign mdu.lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: results, latency, stall/busy windows, ignored starts and CLR.
module tb_ex_muldiv_unit;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;
`ifdef MULDIV_FASTMUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 32;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ex_muldiv_unit_if #(.XLEN(32)) bus ();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .CLR (clr),
        .mdu (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Issue one op from an idle cycle; returns one cycle after the done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input int ebusy);
        int cyc;
        int nbusy;
        int nstall;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        chk({tag, "_stall_acc"}, bus.stall, 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        #1;
        cyc = 1; nbusy = 0; nstall = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy)  nbusy++;
            if (bus.stall) nstall++;
            @(posedge clk);
            #2;
            cyc++;
        end
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_lat"}, cyc, elat);
        chk({tag, "_busy_cyc"}, nbusy, ebusy);
        chk({tag, "_stall_cyc"}, nstall, ebusy);
        chk({tag, "_stall_in_done"}, bus.stall, 0);
        chk({tag, "_hi"}, bus.hi_out, eh);
        chk({tag, "_lo"}, bus.lo_out, el);
        @(posedge clk);
        #2;
        chk({tag, "_done_drop"}, bus.done, 0);
        chk({tag, "_hi_hold"}, bus.hi_out, eh);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        int dlat;
        logic [31:0] dlo;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        #1;
        chk("rst_busy",  bus.busy,   0);
        chk("rst_done",  bus.done,   0);
        chk("rst_stall", bus.stall,  0);
        chk("rst_hi",    bus.hi_out, 0);
        chk("rst_lo",    bus.lo_out, 0);

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, MUL_BUSY);
        run_op("mult_m3x5", MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, MUL_BUSY);
        run_op("mult_nn",   MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0,         32'd6,         MUL_LAT, MUL_BUSY);
        run_op("div_m7d2",  DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 32);
        run_op("div_7dm2",  DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 32);
        run_op("divu_100d7", DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        33, 32);
        run_op("divu_by0",  DIVU,  32'h64,        32'd0,         32'h64,        32'hFFFF_FFFF, 1, 0);
        run_op("div_by0",   DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 0);
        run_op("div_ovf",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 32);

`ifndef MULDIV_FASTMUL_EN
        // A start raised mid-operation must be dropped, not queued.
        bus.start = 1'b1; bus.op = MULTU; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        #1;
        cyc = 1; ndone = 0; dlat = 0; dlo = '0;
        while (cyc < 34) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = DIVU; bus.src_a = 32'd9; bus.src_b = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            #1;
            if (bus.done) begin
                ndone++;
                dlat = cyc;
                dlo  = bus.lo_out;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("seq_ndone", ndone, 1);
        chk("seq_lat",   dlat,  33);
        chk("seq_lo",    dlo,   32'd12);
        run_op("seq_divu", DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33, 32);
`endif

        // CLR mid-divide abandons the operation.
        bus.start = 1'b1; bus.op = DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        #1;
        chk("clr_busy",  bus.busy,   0);
        chk("clr_stall", bus.stall,  0);
        chk("clr_hi",    bus.hi_out, 0);
        chk("clr_lo",    bus.lo_out, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) ndone++;
            @(posedge clk);
            #2;
        end
        chk("clr_no_done", ndone, 0);

        // CLR wins over a simultaneous start.
        bus.start = 1'b1; bus.op = DIVU; bus.src_a = 32'd9; bus.src_b = 32'd3;
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("clrpri_busy", bus.busy, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.stall) ndone++;
            @(posedge clk);
            #2;
        end
        chk("clrpri_idle", ndone, 0);

        run_op("post_clr_divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
